xm23_alu: RTL and testbench

- Registered arithmetic/logic unit for the XM23 CPU datapath.
- Takes the source operand (s_bus) and destination operand (d_bus) plus a 6-bit operation code.
- Produces the result and an updated PSW one clock after enable.
- The control unit writes alu_out back to the register file/MDR and commits PSW_out when psw_update pulses.

---
 rtl/xm23_alu.sv | 234 +++++++++++++++++++++++
 tb/tb_xm23_alu.sv | 136 +++++++++++++
 2 files changed

// File: rtl/xm23_alu.sv
// XM23 datapath ALU: registered result and PSW, one cycle after alu_E.
// Optional BCD add (op 4) is built only when XM23_ALU_DADD_EN is defined.
module xm23_alu (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] s_bus,
    input  logic [15:0] d_bus,
    input  logic [5:0]  alu_op,
    input  logic [15:0] PSW_in,
    input  logic        alu_E,
    output logic [15:0] alu_out,
    output logic [15:0] PSW_out,
    output logic        psw_update
);

    localparam int unsigned W  = 16;
    localparam int unsigned BW = 8;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBC = 5'd3;
    localparam logic [4:0] OP_DADD = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_BIT  = 5'd9;
    localparam logic [4:0] OP_BIC  = 5'd10;
    localparam logic [4:0] OP_BIS  = 5'd11;
    localparam logic [4:0] OP_MOV  = 5'd12;
    localparam logic [4:0] OP_SRA  = 5'd13;
    localparam logic [4:0] OP_RRC  = 5'd14;
    localparam logic [4:0] OP_SWPB = 5'd15;
    localparam logic [4:0] OP_SXT  = 5'd16;

    logic [4:0]    op;
    logic          byte_mode;
    logic          cin;

    assign op        = alu_op[4:0];
    assign byte_mode = alu_op[5];
    assign cin       = PSW_in[0];

    // Byte ops keep the destination's high byte.
    function automatic logic [W-1:0] merge_b(input logic bm, input logic [W-1:0] d,
                                             input logic [W-1:0] x);
        return bm ? {d[W-1:BW], x[BW-1:0]} : x;
    endfunction

`ifdef XM23_ALU_DADD_EN
    // Returns {carry, result}; each nibble above 9 is corrected by +6.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] d, input logic [W-1:0] s,
                                           input logic ci, input logic bm);
        logic [W-1:0] r;
        logic [4:0]   nib;
        logic         c;
        logic         cb;
        r  = '0;
        c  = ci;
        cb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nib = 5'(d[i*4 +: 4]) + 5'(s[i*4 +: 4]) + 5'(c);
            if (nib > 5'd9) begin
                nib = nib + 5'd6;
                c   = 1'b1;
            end else begin
                c   = 1'b0;
            end
            r[i*4 +: 4] = nib[3:0];
            if (i == 1) cb = c;
        end
        return bm ? {cb, d[W-1:BW], r[BW-1:0]} : {c, r};
    endfunction

    logic [W:0] dadd_c;
    assign dadd_c = bcd_add(d_bus, s_bus, cin, byte_mode);
`endif

    // Shared adder: subtraction is D + ~S + carry-in.
    logic [W-1:0] add_b_c;
    logic         add_ci_c;

    always_comb begin
        add_b_c  = s_bus;
        add_ci_c = 1'b0;
        case (op)
            OP_ADDC: add_ci_c = cin;
            OP_SUB, OP_CMP: begin
                add_b_c  = ~s_bus;
                add_ci_c = 1'b1;
            end
            OP_SUBC: begin
                add_b_c  = ~s_bus;
                add_ci_c = cin;
            end
            default: ;
        endcase
    end

    logic [W:0]    sum_w_c;
    logic [BW:0]   sum_b_c;
    logic [W-1:0]  add_res_c;
    logic          add_cout_c;
    logic          add_v_c;
    logic          d_msb_c;
    logic          b_msb_c;
    logic          r_msb_c;

    assign sum_w_c    = {1'b0, d_bus} + {1'b0, add_b_c} + (W+1)'(add_ci_c);
    assign sum_b_c    = {1'b0, d_bus[BW-1:0]} + {1'b0, add_b_c[BW-1:0]} + (BW+1)'(add_ci_c);
    assign add_res_c  = byte_mode ? {d_bus[W-1:BW], sum_b_c[BW-1:0]} : sum_w_c[W-1:0];
    assign add_cout_c = byte_mode ? sum_b_c[BW] : sum_w_c[W];
    assign d_msb_c    = byte_mode ? d_bus[BW-1]     : d_bus[W-1];
    assign b_msb_c    = byte_mode ? add_b_c[BW-1]   : add_b_c[W-1];
    assign r_msb_c    = byte_mode ? add_res_c[BW-1] : add_res_c[W-1];
    assign add_v_c    = (d_msb_c == b_msb_c) && (r_msb_c != d_msb_c);

    logic [W-1:0] res_c;
    logic [W-1:0] flag_src_c;
    logic         c_c;
    logic         v_c;
    logic         ld_c;
    logic         upd_c;
    logic         word_flags_c;

    // Operation select: result, flag source, carry and overflow.
    always_comb begin
        res_c        = alu_out;
        flag_src_c   = alu_out;
        c_c          = cin;
        v_c          = 1'b0;
        ld_c         = 1'b1;
        upd_c        = 1'b1;
        word_flags_c = 1'b0;
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                res_c      = add_res_c;
                flag_src_c = add_res_c;
                c_c        = add_cout_c;
                v_c        = add_v_c;
            end
            OP_CMP: begin
                res_c      = d_bus;
                flag_src_c = add_res_c;
                c_c        = add_cout_c;
                v_c        = add_v_c;
            end
`ifdef XM23_ALU_DADD_EN
            OP_DADD: begin
                res_c      = dadd_c[W-1:0];
                flag_src_c = dadd_c[W-1:0];
                c_c        = dadd_c[W];
            end
`endif
            OP_XOR: begin
                res_c      = merge_b(byte_mode, d_bus, d_bus ^ s_bus);
                flag_src_c = res_c;
            end
            OP_AND: begin
                res_c      = merge_b(byte_mode, d_bus, d_bus & s_bus);
                flag_src_c = res_c;
            end
            OP_OR, OP_BIS: begin
                res_c      = merge_b(byte_mode, d_bus, d_bus | s_bus);
                flag_src_c = res_c;
            end
            OP_BIT: begin
                res_c      = d_bus;
                flag_src_c = d_bus & s_bus;
            end
            OP_BIC: begin
                res_c      = merge_b(byte_mode, d_bus, d_bus & ~s_bus);
                flag_src_c = res_c;
            end
            OP_MOV: begin
                res_c = merge_b(byte_mode, d_bus, s_bus);
                upd_c = 1'b0;
            end
            OP_SRA: begin
                res_c      = byte_mode ? {d_bus[W-1:BW], d_bus[BW-1], d_bus[BW-1:1]}
                                       : {d_bus[W-1], d_bus[W-1:1]};
                flag_src_c = res_c;
                c_c        = d_bus[0];
            end
            OP_RRC: begin
                res_c      = byte_mode ? {d_bus[W-1:BW], cin, d_bus[BW-1:1]}
                                       : {cin, d_bus[W-1:1]};
                flag_src_c = res_c;
                c_c        = d_bus[0];
            end
            OP_SWPB: begin
                res_c        = {d_bus[BW-1:0], d_bus[W-1:BW]};
                flag_src_c   = res_c;
                word_flags_c = 1'b1;
            end
            OP_SXT: begin
                res_c        = {{BW{d_bus[BW-1]}}, d_bus[BW-1:0]};
                flag_src_c   = res_c;
                word_flags_c = 1'b1;
            end
            default: begin
                ld_c  = 1'b0;
                upd_c = 1'b0;
            end
        endcase
    end

    logic         fbyte_c;
    logic         z_c;
    logic         n_c;
    logic [W-1:0] psw_c;

    assign fbyte_c = byte_mode && !word_flags_c;
    assign z_c     = fbyte_c ? (flag_src_c[BW-1:0] == '0) : (flag_src_c == '0);
    assign n_c     = fbyte_c ? flag_src_c[BW-1] : flag_src_c[W-1];
    assign psw_c   = upd_c ? {PSW_in[W-1:5], v_c, PSW_in[3], n_c, z_c, c_c} : PSW_in;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            alu_out    <= '0;
            PSW_out    <= '0;
            psw_update <= 1'b0;
        end else begin
            psw_update <= 1'b0;
            if (alu_E && ld_c) begin
                alu_out    <= res_c;
                PSW_out    <= psw_c;
                psw_update <= upd_c;
            end
        end
    end

endmodule

// File: tb/tb_xm23_alu.sv
// Scoreboard bench for xm23_alu: driver queues expectations, monitor checks outputs.
module tb_xm23_alu;

    logic        Clock;
    logic        Reset;
    logic [15:0] s_bus;
    logic [15:0] d_bus;
    logic [5:0]  alu_op;
    logic [15:0] PSW_in;
    logic        alu_E;
    logic [15:0] alu_out;
    logic [15:0] PSW_out;
    logic        psw_update;

    xm23_alu dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .s_bus      (s_bus),
        .d_bus      (d_bus),
        .alu_op     (alu_op),
        .PSW_in     (PSW_in),
        .alu_E      (alu_E),
        .alu_out    (alu_out),
        .PSW_out    (PSW_out),
        .psw_update (psw_update)
    );

    typedef struct packed {
        logic [15:0] out;
        logic [15:0] psw;
        logic        upd;
        int          due;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got 0x%04h, expected 0x%04h", nm, fld, act, req);
    endtask

    // Monitor: compare each captured cycle after its clock edge has passed.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge Clock);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "alu_out", alu_out, e.out);
                chk(nm, "PSW_out", PSW_out, e.psw);
                chk(nm, "psw_update", 16'(psw_update), 16'(e.upd));
            end
        end
    end

    task automatic issue(input string nm, input logic rst, input logic en, input logic [5:0] op,
                         input logic [15:0] d, input logic [15:0] s, input logic [15:0] psw,
                         input logic [15:0] x_out, input logic [15:0] x_psw, input logic x_upd);
        exp_t e;
        @(posedge Clock);
        #1;
        Reset  = rst;
        alu_E  = en;
        alu_op = op;
        d_bus  = d;
        s_bus  = s;
        PSW_in = psw;
        e.out  = x_out;
        e.psw  = x_psw;
        e.upd  = x_upd;
        e.due  = cyc + 1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        Reset  = 1'b1;
        alu_E  = 1'b0;
        alu_op = '0;
        d_bus  = '0;
        s_bus  = '0;
        PSW_in = '0;

        issue("reset",      1, 1, 6'h00, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0);
        issue("add_ovf",    0, 1, 6'h00, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0014, 1);
        issue("idle_hold",  0, 0, 6'h00, 16'h1111, 16'h2222, 16'h00FF, 16'h8000, 16'h0014, 0);
        issue("sub_zero",   0, 1, 6'h02, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0003, 1);
        issue("cmp_neg",    0, 1, 6'h05, 16'h0003, 16'h0005, 16'h0000, 16'h0003, 16'h0004, 1);
        issue("add_byte",   0, 1, 6'h20, 16'h12FF, 16'h0001, 16'h0000, 16'h1200, 16'h0003, 1);
        issue("rrc_out",    0, 1, 6'h0E, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 1);
        issue("rrc_in",     0, 1, 6'h0E, 16'h0000, 16'h0000, 16'h0001, 16'h8000, 16'h0004, 1);
        issue("xor_psw",    0, 1, 6'h06, 16'h00FF, 16'h00FF, 16'hFFE9, 16'h0000, 16'hFFEB, 1);
        issue("subc_byte",  0, 1, 6'h23, 16'hAA80, 16'h0001, 16'h0001, 16'hAA7F, 16'h0011, 1);
        issue("sra_word",   0, 1, 6'h0D, 16'h8003, 16'h0000, 16'h0000, 16'hC001, 16'h0005, 1);
        issue("swpb_bm",    0, 1, 6'h2F, 16'h00F0, 16'h0000, 16'h0000, 16'hF000, 16'h0004, 1);
        issue("sxt",        0, 1, 6'h10, 16'h1280, 16'h0000, 16'h0000, 16'hFF80, 16'h0004, 1);
        issue("bit",        0, 1, 6'h09, 16'h00F0, 16'h000F, 16'h0001, 16'h00F0, 16'h0003, 1);
        issue("bic_byte",   0, 1, 6'h2A, 16'h55FF, 16'h000F, 16'h0000, 16'h55F0, 16'h0004, 1);
        issue("undef_op",   0, 1, 6'h14, 16'h1234, 16'h4321, 16'h00FF, 16'h55F0, 16'h0004, 0);
        issue("mov",        0, 1, 6'h0C, 16'h0000, 16'hABCD, 16'h001F, 16'hABCD, 16'h001F, 0);
`ifdef XM23_ALU_DADD_EN
        issue("dadd_carry", 0, 1, 6'h04, 16'h0999, 16'h0001, 16'h0000, 16'h1000, 16'h0000, 1);
        issue("dadd_wrap",  0, 1, 6'h04, 16'h9999, 16'h0001, 16'h0000, 16'h0000, 16'h0003, 1);
`else
        issue("dadd_off1",  0, 1, 6'h04, 16'h0999, 16'h0001, 16'h0000, 16'hABCD, 16'h001F, 0);
        issue("dadd_off2",  0, 1, 6'h04, 16'h9999, 16'h0001, 16'h0000, 16'hABCD, 16'h001F, 0);
`endif
        issue("addc_wrap",  0, 1, 6'h01, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0003, 1);
        issue("or_clr_v",   0, 1, 6'h08, 16'h8000, 16'h0001, 16'h0010, 16'h8001, 16'h0004, 1);
        issue("reset_mid",  1, 0, 6'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        issue("post_reset", 0, 0, 6'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
        @(negedge Clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
